// File: rtl/ontransitdd_1.sv
// ontransitdd_1 -- turns a level request into registered start/stop strobes.
//
// A small FSM (IDLE -> RUN -> STOP -> IDLE) tracks the request level and
// emits one-cycle pulses on its transitions:
//   g_o : registered go strobe, high for the cycle after entering RUN
//   s_o : registered stop strobe, high for the cycle after leaving RUN
// Once entered, RUN is held for at least MIN_RUN cycles. STOP always lasts
// exactly one cycle, so a new g_o comes at least two cycles after s_o.
//
// Ports
//   clk_i  : clock; all logic is on the rising edge
//   rst_i  : synchronous reset, active high
//   do_i   : level request (1 = run requested)
//   g_o    : go strobe, 1 cycle wide
//   s_o    : stop strobe, 1 cycle wide
//
// Parameters
//   MIN_RUN : minimum dwell in RUN before exit is allowed (1..255)
//   CNT_W   : dwell counter width; must be able to hold MIN_RUN
//
// Build option
//   ONTRANSITDD_SYNC_EN : when defined, do_i passes through a 2-flop
//   synchronizer (reset to 0) before the FSM. All do->strobe latencies then
//   grow by 2 cycles. When undefined, do_i must already be synchronous to
//   clk_i and is used directly.
module ontransitdd_1 #(
  parameter int unsigned MIN_RUN = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic do_i,
  output logic g_o,
  output logic s_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_q;

`ifdef ONTRANSITDD_SYNC_EN
  // Two-stage synchronizer; sync_q[1] is the resolved request level.
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], do_i};
  end

  assign do_q = sync_q[1];
`else
  assign do_q = do_i;
`endif

  // Strobes are cleared every cycle and only set on the transition that
  // produces them, so each one is high for exactly one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      g_o     <= 1'b0;
      s_o     <= 1'b0;
    end else begin
      g_o <= 1'b0;
      s_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (do_q) begin
            state_q <= RUN;
            cnt_q   <= CNT_W'(1);
            g_o     <= 1'b1;
          end
        end
        RUN: begin
          // cnt_q counts the cycles already spent in RUN and saturates at
          // MIN_RUN. An early drop of the request is remembered only by its
          // level: if it has come back by the time the dwell is met, no stop.
          if ((cnt_q >= MIN_RUN_C) && !do_q) begin
            state_q <= STOP;
            cnt_q   <= '0;
            s_o     <= 1'b1;
          end else if (cnt_q < MIN_RUN_C) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          // One mandatory cycle here keeps g_o at least 2 cycles after s_o.
          state_q <= IDLE;
        end
        default: begin
          // Encoding 2'b11 cannot be reached; recover to IDLE quietly.
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ontransitdd_1.sv
// Bench for ontransitdd_1: directed scenarios followed by random request
// and reset traffic. Each cycle is checked against an event-time model that
// only records when the last go and stop happened. It keeps no state
// encoding and no dwell counter.
module tb_ontransitdd_1;

  localparam int MIN_RUN = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic do_i  = 1'b0;
  logic g_o, s_o;

  int total = 0;
  int bad   = 0;

  ontransitdd_1 #(.MIN_RUN(MIN_RUN), .CNT_W(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .do_i  (do_i),
    .g_o   (g_o),
    .s_o   (s_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: edge index, and the edge indices of the last go and
  // the last stop. Dwell time in RUN is simply k - t_go.
  int k       = 0;
  int t_go    = 0;
  int t_stop  = -100;
  bit running = 1'b0;
  bit h1 = 1'b0, h2 = 1'b0;  // request history, used in the synchronized build
  int last_g  = -1;
  int last_s  = -1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %b want %b", tag, k, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit d);
    bit dq, eg, es;
    rst_i = r;
    do_i  = d;
    @(posedge clk_i);
    k++;
`ifdef ONTRANSITDD_SYNC_EN
    dq = h2;
`else
    dq = d;
`endif
    eg = 1'b0;
    es = 1'b0;
    if (r) begin
      running = 1'b0;
      t_stop  = -100;
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      h2 = h1;
      h1 = d;
      if (running) begin
        if ((k - t_go) >= MIN_RUN && !dq) begin
          running = 1'b0;
          t_stop  = k;
          es      = 1'b1;
        end
      end else if ((k - t_stop) >= 2 && dq) begin
        running = 1'b1;
        t_go    = k;
        eg      = 1'b1;
      end
    end
    #1;
    chk("g", g_o, eg);
    chk("s", s_o, es);
    if (g_o) last_g = k;
    if (s_o) last_s = k;
  endtask

  initial begin
    // 1: reset held, request low
    step(1, 0);
    step(1, 0);
    // 2: request rises and is held for 10 cycles
    step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 1);
    // 3: drop, then re-request straight away
    step(0, 0);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    // 4: single-cycle request gives s exactly MIN_RUN cycles after g
    step(0, 0);
    for (int i = 0; i < 4; i++) step(0, 0);
    step(0, 1);
    step(0, 0);
    step(0, 0);
    step(0, 0);
`ifndef ONTRANSITDD_SYNC_EN
    chk("gap", (last_s - last_g) == MIN_RUN, 1'b1);
`endif
    step(0, 0);
    step(0, 0);
    // 4b: request dropped, then raised again before the dwell is met
    step(0, 1);
    step(0, 0);
    step(0, 1);
    for (int i = 0; i < 5; i++) step(0, 1);
    // 5: reset in RUN with request high, then release
    step(1, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    // random traffic: long request runs, occasional short glitches and resets
    for (int i = 0; i < 600; i++) begin
      bit r, d;
      r = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) d = ~do_i;
      else                           d = do_i;
      step(r, d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
